intr_sched: RTL and testbench

- Clocked interrupt scheduler for the single-cycle CPU's I/O interrupt path. It latches requests on the four input-port interrupt lines and arbitrates them by fixed priority. It hands one subroutine vector at a time to the PC-select logic through a request/acknowledge handshake, and blocks further interrupts until the subroutine signals completion.
- It sits between the I/O ports and the PC mux/control unit.
- It also stores the return address and provides a CPU-writable enable mask.

---
 rtl/intr_sched_pkg.sv | 18 +
 rtl/intr_sched_prio_enc4.sv | 17 +
 rtl/intr_sched.sv | 117 +++++++++++
 tb/tb_intr_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_sched_pkg.sv
// Shared types and default constants for the interrupt scheduler.
// Holds the FSM state encoding and the per-port subroutine vectors.
package intr_sched_pkg;

  localparam int ADDR_W_DEF = 10;

  localparam logic [9:0] VEC0_DEF = 10'd984;
  localparam logic [9:0] VEC1_DEF = 10'd994;
  localparam logic [9:0] VEC2_DEF = 10'd1004;
  localparam logic [9:0] VEC3_DEF = 10'd1014;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intr_sched_prio_enc4.sv
// Combinational 4-to-2 fixed-priority encoder; bit 0 has the highest priority.
module prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    idx = 2'd0;
    vld = |req;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
  end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: latches irq rising edges, arbitrates by fixed priority and
// hands one vector at a time to the PC-select logic, blocking nesting until fin.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] VEC0     = VEC0_DEF,
  parameter logic [ADDR_W-1:0] VEC1     = VEC1_DEF,
  parameter logic [ADDR_W-1:0] VEC2     = VEC2_DEF,
  parameter logic [ADDR_W-1:0] VEC3     = VEC3_DEF,
  parameter logic [3:0]        MASK_RST = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        irq,
  input  logic              mask_we,
  input  logic [3:0]        mask_wdata,
  input  logic              ack,
  input  logic              fin,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              s_interrup,
  output logic [ADDR_W-1:0] dir,
  output logic [ADDR_W-1:0] ret_dir,
  output logic              busy,
  output logic [3:0]        pending,
  output logic [3:0]        mask
);

  state_t     state;
  logic [3:0] irq_q;
  logic [1:0] sel;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [1:0] enc_idx;
  logic       enc_vld;

  function automatic logic [ADDR_W-1:0] vec_of(input logic [1:0] i);
    case (i)
      2'd0:    vec_of = VEC0;
      2'd1:    vec_of = VEC1;
      2'd2:    vec_of = VEC2;
      default: vec_of = VEC3;
    endcase
  endfunction

  assign rise     = irq & ~irq_q;
  assign eligible = pending & mask;

  prio_enc4 u_prio_enc4 (
    .req (eligible),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  // Only the bit being acknowledged is cleared; a same-cycle rise re-sets it below.
  always_comb begin
    clr = 4'b0000;
    if (state == REQ && ack) clr[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq_q      <= 4'b0000;
      pending    <= 4'b0000;
      mask       <= MASK_RST;
      sel        <= 2'd0;
      s_interrup <= 1'b0;
      busy       <= 1'b0;
      dir        <= '0;
      ret_dir    <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;

      case (state)
        IDLE: begin
          if (enc_vld) begin
            sel        <= enc_idx;
            state      <= REQ;
            s_interrup <= 1'b1;
            dir        <= vec_of(enc_idx);
          end
        end
        REQ: begin
          if (ack) begin
            ret_dir    <= pc_in;
            state      <= SERVICE;
            s_interrup <= 1'b0;
            busy       <= 1'b1;
          end else if (!mask[sel]) begin
            // Line was masked while waiting: withdraw but keep it pending.
            state      <= IDLE;
            s_interrup <= 1'b0;
            dir        <= '0;
          end
        end
        SERVICE: begin
          if (fin) begin
            state <= IDLE;
            busy  <= 1'b0;
            dir   <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          s_interrup <= 1'b0;
          busy       <= 1'b0;
          dir        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_sched.sv
// Directed plus randomized bench for intr_sched against a cycle-level behavioural model.
module tb_intr_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq = 4'b0000;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0000;
  logic       ack = 1'b0;
  logic       fin = 1'b0;
  logic [9:0] pc_in = 10'd0;
  logic       s_interrup;
  logic [9:0] dir;
  logic [9:0] ret_dir;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] mask;

  int vectors = 0;
  int miscompares = 0;

  intr_sched dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .fin        (fin),
    .pc_in      (pc_in),
    .s_interrup (s_interrup),
    .dir        (dir),
    .ret_dir    (ret_dir),
    .busy       (busy),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = nothing offered, 1 = vector offered, 2 = in subroutine.
  int         vec_tab[4] = '{984, 994, 1004, 1014};
  int         m_phase;
  int         m_sel;
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [3:0] m_prev_irq;
  logic [9:0] m_ret;

  task automatic m_reset();
    m_phase = 0; m_sel = 0; m_pend = 4'b0000; m_mask = 4'b1111;
    m_prev_irq = 4'b0000; m_ret = 10'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s_interrup"}, 32'(s_interrup), 32'(m_phase == 1));
    chk({tag, ".busy"},       32'(busy),       32'(m_phase == 2));
    chk({tag, ".dir"},        32'(dir),        (m_phase == 0) ? 32'd0 : 32'(vec_tab[m_sel]));
    chk({tag, ".ret_dir"},    32'(ret_dir),    32'(m_ret));
    chk({tag, ".pending"},    32'(pending),    32'(m_pend));
    chk({tag, ".mask"},       32'(mask),       32'(m_mask));
  endtask

  // Apply the current inputs for one clock edge, advance the model, then compare.
  task automatic cycle(input string tag = "cyc");
    logic [3:0] new_edges, eligible, served;
    int         nphase, nsel;
    logic [9:0] nret;
    new_edges = irq & ~m_prev_irq;
    served = 4'b0000;
    nphase = m_phase; nsel = m_sel; nret = m_ret;
    if (m_phase == 0) begin
      eligible = m_pend & m_mask;
      for (int i = 3; i >= 0; i--) if (eligible[i]) begin nsel = i; nphase = 1; end
    end else if (m_phase == 1) begin
      if (ack) begin
        served[m_sel] = 1'b1; nret = pc_in; nphase = 2;
      end else if (!m_mask[m_sel]) begin
        nphase = 0;
      end
    end else if (fin) begin
      nphase = 0;
    end
    @(posedge clk);
    #1;
    m_pend = (m_pend & ~served) | new_edges;
    if (mask_we) m_mask = mask_wdata;
    m_prev_irq = irq;
    m_phase = nphase; m_sel = nsel; m_ret = nret;
    check_all(tag);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (s_interrup !== 1'b1 && n < 10) begin
      cycle(tag);
      n++;
    end
    chk({tag, ".req_seen"}, 32'(s_interrup), 32'd1);
  endtask

  task automatic serve(input string tag, input int exp_dir, input logic [3:0] exp_pend,
                       input logic [9:0] pc);
    wait_req(tag);
    chk({tag, ".vector"}, 32'(dir), 32'(exp_dir));
    ack = 1'b1; pc_in = pc;
    cycle(tag);
    ack = 1'b0;
    chk({tag, ".in_service"}, 32'(busy), 32'd1);
    chk({tag, ".req_dropped"}, 32'(s_interrup), 32'd0);
    chk({tag, ".ret"}, 32'(ret_dir), 32'(pc));
    chk({tag, ".pend_after_ack"}, 32'(pending), 32'(exp_pend));
    fin = 1'b1;
    cycle(tag);
    fin = 1'b0;
    chk({tag, ".done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         nserv;
    logic       prev_busy;
    m_reset();
    #12;
    check_all("reset");
    chk("reset.mask", 32'(mask), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Single request on port 2.
    irq = 4'b0010;
    cycle("p2_edge");
    chk("p2_no_req_yet", 32'(s_interrup), 32'd0);
    cycle("p2_req");
    chk("p2_req_2cyc", 32'(s_interrup), 32'd1);
    chk("p2_dir", 32'(dir), 32'd994);
    serve("p2", 994, 4'b0000, 10'd37);
    irq = 4'b0000;
    cycle();

    // Three simultaneous edges served in priority order.
    irq = 4'b1101;
    cycle();
    chk("multi_pend", 32'(pending), 32'b1101);
    serve("multi0", 984, 4'b1100, 10'd100);
    serve("multi2", 1004, 4'b1000, 10'd200);
    serve("multi3", 1014, 4'b0000, 10'd300);
    irq = 4'b0000;
    cycle();

    // No nesting: port 1 arrives during port 3's subroutine.
    irq = 4'b0100;
    wait_req("nest");
    ack = 1'b1; pc_in = 10'd55;
    cycle("nest");
    ack = 1'b0;
    irq = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      cycle("nest_hold");
      chk("nest_no_req", 32'(s_interrup), 32'd0);
    end
    fin = 1'b1;
    cycle("nest");
    fin = 1'b0;
    serve("nest_next", 984, 4'b0000, 10'd56);
    irq = 4'b0000;
    cycle();

    // Masked line latches but does not request until re-enabled.
    mask_we = 1'b1; mask_wdata = 4'b1110;
    cycle("mask_wr");
    mask_we = 1'b0;
    irq = 4'b0001;
    repeat (3) cycle("masked");
    chk("masked_pend", 32'(pending), 32'b0001);
    chk("masked_no_req", 32'(s_interrup), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    cycle("unmask");
    mask_we = 1'b0;
    chk("unmask_not_yet", 32'(s_interrup), 32'd0);
    cycle("unmask");
    chk("unmask_req", 32'(s_interrup), 32'd1);
    chk("unmask_dir", 32'(dir), 32'd984);
    serve("unmask", 984, 4'b0000, 10'd7);
    irq = 4'b0000;
    cycle();

    // Withdraw when masked while waiting for ack.
    irq = 4'b0010;
    wait_req("wd");
    mask_we = 1'b1; mask_wdata = 4'b1101;
    cycle("wd_mask");
    mask_we = 1'b0;
    cycle("wd");
    chk("wd_no_req", 32'(s_interrup), 32'd0);
    chk("wd_pend_kept", 32'(pending[1]), 32'd1);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    cycle("wd_unmask");
    mask_we = 1'b0;
    serve("wd_after", 994, 4'b0000, 10'd9);
    irq = 4'b0000;
    cycle();

    // Held level gives exactly one service.
    irq = 4'b1000;
    nserv = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ack = (s_interrup === 1'b1);
      fin = (busy === 1'b1);
      pc_in = 10'(i);
      cycle("level");
      if (busy === 1'b1 && prev_busy !== 1'b1) nserv++;
      prev_busy = busy;
    end
    ack = 1'b0; fin = 1'b0;
    chk("level_one_service", 32'(nserv), 32'd1);
    irq = 4'b0000;
    cycle();

    // Asynchronous reset mid-service.
    irq = 4'b1000;
    wait_req("arst");
    ack = 1'b1; pc_in = 10'd444;
    cycle("arst");
    ack = 1'b0;
    chk("arst_busy", 32'(busy), 32'd1);
    irq = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_all("arst");
    chk("arst_ret", 32'(ret_dir), 32'd0);
    chk("arst_mask", 32'(mask), 32'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    cycle("arst_rel");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      ack        = ($urandom_range(0, 2) == 0);
      fin        = ($urandom_range(0, 3) == 0);
      mask_we    = ($urandom_range(0, 11) == 0);
      mask_wdata = 4'($urandom);
      pc_in      = 10'($urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
